// File: rtl/perceptron_train_ctrl.sv
// Perceptron training controller: holds a small sample store and runs the
// perceptron learning rule over it, epoch by epoch, until convergence or the epoch limit.
module perceptron_train_ctrl #(
  parameter int N_SAMPLES  = 3,
  parameter int DIM        = 2,
  parameter int MAX_EPOCHS = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [8:0]  wr_data,
  input  logic [15:0] w_init,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        converged,
  output logic [3:0]  epoch,
  output logic [15:0] w_out,
  output logic        act_out
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_MAC       = 3'd1;
  localparam logic [2:0] S_ACT       = 3'd2;
  localparam logic [2:0] S_UPD       = 3'd3;
  localparam logic [2:0] S_EPOCH_END = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  localparam logic [3:0] ADDR_LAST = 4'(N_SAMPLES - 1);
  localparam logic [3:0] EPOCH_LIM = 4'(MAX_EPOCHS);
  localparam logic       D_LAST    = 1'(DIM - 1);

  logic [2:0]         state;
  logic [8:0]         samp_mem [16];
  logic signed [7:0]  w0, w1;
  logic signed [15:0] acc;
  logic [3:0]         err_cnt;
  logic [3:0]         idx;
  logic               d_sel;
  logic signed [1:0]  delta;

  logic [8:0]         cur;
  logic [3:0]         cur_x0, cur_x1, x_sel;
  logic               cur_y;
  logic signed [7:0]  w_sel;
  logic signed [12:0] prod;
  logic signed [15:0] acc_next;
  logic               act;
  logic signed [1:0]  delta_next;

  // Adds delta*x to a weight and clamps to the signed 8-bit range.
  function automatic logic [7:0] sat_step(input logic signed [7:0] w,
                                          input logic [3:0] x,
                                          input logic signed [1:0] dl);
    logic signed [9:0] xs;
    logic signed [9:0] s;
    logic [7:0]        r;
    xs = $signed({6'd0, x});
    s  = $signed({{2{w[7]}}, w});
    if (dl == 2'sb01)
      s = s + xs;
    else if (dl == 2'sb11)
      s = s - xs;
    if (s > 10'sd127)
      r = 8'h7F;
    else if (s < -10'sd128)
      r = 8'h80;
    else
      r = s[7:0];
    return r;
  endfunction

  assign cur        = samp_mem[idx];
  assign cur_x0     = cur[3:0];
  assign cur_x1     = cur[7:4];
  assign cur_y      = cur[8];
  assign x_sel      = d_sel ? cur_x1 : cur_x0;
  assign w_sel      = d_sel ? w1 : w0;
  assign prod       = $signed({1'b0, x_sel}) * w_sel;
  assign acc_next   = acc + $signed({{3{prod[12]}}, prod});
  assign act        = (acc > 16'sd0);
  assign delta_next = $signed({1'b0, cur_y}) - $signed({1'b0, act});

  assign busy  = (state != S_IDLE);
  assign done  = (state == S_DONE);
  assign w_out = {w1, w0};

  // The store only accepts writes while idle so a run always sees stable samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++)
        samp_mem[i] <= '0;
    end else if (state == S_IDLE && wr_en && wr_addr <= ADDR_LAST) begin
      samp_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      w0        <= '0;
      w1        <= '0;
      acc       <= '0;
      err_cnt   <= '0;
      idx       <= '0;
      d_sel     <= 1'b0;
      delta     <= '0;
      epoch     <= '0;
      converged <= 1'b0;
      act_out   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            w0        <= w_init[7:0];
            w1        <= w_init[15:8];
            idx       <= '0;
            err_cnt   <= '0;
            epoch     <= '0;
            converged <= 1'b0;
            acc       <= '0;
            d_sel     <= 1'b0;
            state     <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc_next;
          if (d_sel == D_LAST) begin
            d_sel <= 1'b0;
            state <= S_ACT;
          end else begin
            d_sel <= d_sel + 1'b1;
          end
        end
        S_ACT: begin
          act_out <= act;
          delta   <= delta_next;
          state   <= S_UPD;
        end
        S_UPD: begin
          w0 <= sat_step(w0, cur_x0, delta);
          w1 <= sat_step(w1, cur_x1, delta);
          if (delta != 2'sd0 && err_cnt != 4'hF)
            err_cnt <= err_cnt + 4'd1;
          if (idx == ADDR_LAST) begin
            state <= S_EPOCH_END;
          end else begin
            idx   <= idx + 4'd1;
            acc   <= '0;
            d_sel <= 1'b0;
            state <= S_MAC;
          end
        end
        // An error-free epoch ends the run; otherwise retry until the limit.
        S_EPOCH_END: begin
          epoch <= epoch + 4'd1;
          if (err_cnt == 4'd0) begin
            converged <= 1'b1;
            state     <= S_DONE;
          end else if (epoch + 4'd1 == EPOCH_LIM) begin
            converged <= 1'b0;
            state     <= S_DONE;
          end else begin
            err_cnt <= '0;
            idx     <= '0;
            acc     <= '0;
            d_sel   <= 1'b0;
            state   <= S_MAC;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// Self-checking bench for perceptron_train_ctrl: a behavioural model fills a
// scoreboard of per-sample results that is drained as the DUT evaluates each sample.
module tb_perceptron_train_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [8:0]  wr_data;
  logic [15:0] w_init;
  logic        start3, start2;
  logic        busy3, done3, conv3, act3;
  logic [3:0]  epoch3;
  logic [15:0] wout3;
  logic        busy2, done2, conv2, act2;
  logic [3:0]  epoch2;
  logic [15:0] wout2;

  perceptron_train_ctrl #(.N_SAMPLES(3), .DIM(2), .MAX_EPOCHS(15)) dut3 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .w_init(w_init), .start(start3), .busy(busy3), .done(done3), .converged(conv3),
    .epoch(epoch3), .w_out(wout3), .act_out(act3)
  );

  perceptron_train_ctrl #(.N_SAMPLES(2), .DIM(2), .MAX_EPOCHS(15)) dut2 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .w_init(w_init), .start(start2), .busy(busy2), .done(done2), .converged(conv2),
    .epoch(epoch2), .w_out(wout2), .act_out(act2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic        act;
    logic [15:0] w;
  } ev_t;

  ev_t         sb[$];
  logic [8:0]  mdl_samp [16];
  int          exp_done, exp_epoch;
  logic        exp_conv;
  logic [15:0] exp_w;
  int          total, bad;
  int          done_seen_cyc;

  function automatic int clamp8(input int v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return v;
  endfunction

  // Behavioural perceptron; cycle stamps follow 4 cycles per sample plus 1 per epoch end.
  task automatic model_run(input int n, input logic [15:0] wi);
    int w0, w1, errs, e, k, a, act, d, x0, x1, y;
    logic signed [7:0] t0, t1;
    ev_t ev;
    t0 = wi[7:0];
    t1 = wi[15:8];
    w0 = t0;
    w1 = t1;
    sb.delete();
    for (e = 0; e < 15; e++) begin
      errs = 0;
      for (k = 0; k < n; k++) begin
        x0  = int'(mdl_samp[k][3:0]);
        x1  = int'(mdl_samp[k][7:4]);
        y   = int'(mdl_samp[k][8]);
        a   = x0 * w0 + x1 * w1;
        act = (a > 0) ? 1 : 0;
        d   = y - act;
        if (d != 0) begin
          errs++;
          w0 = clamp8(w0 + d * x0);
          w1 = clamp8(w1 + d * x1);
        end
        ev.cyc = e * (4 * n + 1) + 4 * k + 4;
        ev.act = (act == 1);
        ev.w   = {8'(w1), 8'(w0)};
        sb.push_back(ev);
      end
      if (errs == 0) begin
        exp_conv = 1'b1;
        break;
      end
      if (e + 1 == 15) begin
        exp_conv = 1'b0;
        break;
      end
    end
    exp_epoch = e + 1;
    exp_done  = exp_epoch * (4 * n + 1);
    exp_w     = {8'(w1), 8'(w0)};
  endtask

  task automatic write_sample(input logic [3:0] a, input int x0, input int x1, input logic y);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = {y, 4'(x1), 4'(x0)};
    if (a < 4'd3) mdl_samp[a] = wr_data;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Starts one DUT and drains the scoreboard; mode 1 pokes start/wr_en while busy,
  // mode 2 holds start during the DONE cycle.
  task automatic run_dut(input int which, input int mode);
    int          cyc;
    ev_t         ev;
    logic        b, d, a, cv;
    logic [15:0] w;
    logic [3:0]  ep;
    done_seen_cyc = -1;
    @(negedge clk);
    if (which == 2) start2 = 1'b1; else start3 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    start3 = 1'b0;
    cyc = 0;
    while (cyc <= exp_done + 1) begin
      start3  = (which == 3) && ((mode == 1 && cyc == 2) || (mode == 2 && cyc == exp_done));
      start2  = (which == 2) && ((mode == 1 && cyc == 2) || (mode == 2 && cyc == exp_done));
      wr_en   = (mode == 1 && cyc == 2);
      wr_addr = 4'd0;
      wr_data = 9'h1FF;
      b = (which == 2) ? busy2 : busy3;
      d = (which == 2) ? done2 : done3;
      a = (which == 2) ? act2 : act3;
      w = (which == 2) ? wout2 : wout3;
      if (d === 1'b1) done_seen_cyc = cyc;
      total++;
      if (d !== (cyc == exp_done)) begin
        bad++;
        $display("[TB] FAIL done cyc=%0d: got %b want %b", cyc, d, (cyc == exp_done));
      end
      total++;
      if (b !== (cyc != exp_done + 1)) begin
        bad++;
        $display("[TB] FAIL busy cyc=%0d: got %b want %b", cyc, b, (cyc != exp_done + 1));
      end
      while (sb.size() > 0 && sb[0].cyc == cyc) begin
        ev = sb.pop_front();
        total++;
        if (a !== ev.act) begin
          bad++;
          $display("[TB] FAIL act_out cyc=%0d: got %b want %b", cyc, a, ev.act);
        end
        total++;
        if (w !== ev.w) begin
          bad++;
          $display("[TB] FAIL w_out cyc=%0d: got %h want %h", cyc, w, ev.w);
        end
      end
      @(negedge clk);
      cyc++;
    end
    start2 = 1'b0;
    start3 = 1'b0;
    wr_en  = 1'b0;
    b  = (which == 2) ? busy2 : busy3;
    cv = (which == 2) ? conv2 : conv3;
    ep = (which == 2) ? epoch2 : epoch3;
    w  = (which == 2) ? wout2 : wout3;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_left: got %0d want 0", sb.size());
      sb.delete();
    end
    total++;
    if (b !== 1'b0) begin bad++; $display("[TB] FAIL idle_busy: got %b want 0", b); end
    total++;
    if (cv !== exp_conv) begin bad++; $display("[TB] FAIL converged: got %b want %b", cv, exp_conv); end
    total++;
    if (ep !== 4'(exp_epoch)) begin bad++; $display("[TB] FAIL epoch: got %0d want %0d", ep, exp_epoch); end
    total++;
    if (w !== exp_w) begin bad++; $display("[TB] FAIL final_w: got %h want %h", w, exp_w); end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({busy3, done3, conv3, act3} !== 4'b0000) begin
      bad++; $display("[TB] FAIL reset_flags: got %b want 0000", {busy3, done3, conv3, act3});
    end
    total++;
    if (epoch3 !== 4'd0) begin bad++; $display("[TB] FAIL reset_epoch: got %0d want 0", epoch3); end
    total++;
    if (wout3 !== 16'h0000) begin bad++; $display("[TB] FAIL reset_w: got %h want 0000", wout3); end
    total++;
    if (busy2 !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy2: got %b want 0", busy2); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic write_known;
    write_sample(4'd0, 2, 3, 1'b0);
    write_sample(4'd1, 4, 5, 1'b1);
    write_sample(4'd2, 1, 2, 1'b1);
  endtask

  task automatic test_known;
    write_known();
    write_sample(4'd3, 15, 15, 1'b1);
    write_sample(4'd15, 15, 15, 1'b1);
    w_init = {8'sd9, 8'sd4};
    model_run(3, w_init);
    run_dut(3, 0);
  endtask

  task automatic test_all_positive;
    write_sample(4'd0, 1, 2, 1'b1);
    write_sample(4'd1, 3, 4, 1'b1);
    write_sample(4'd2, 5, 6, 1'b1);
    w_init = {8'sd1, 8'sd1};
    model_run(3, w_init);
    run_dut(3, 0);
    total++;
    if (done_seen_cyc != 13) begin bad++; $display("[TB] FAIL done_latency: got %0d want 13", done_seen_cyc); end
    total++;
    if (epoch3 !== 4'd1 || conv3 !== 1'b1) begin
      bad++; $display("[TB] FAIL all_pos_result: got epoch=%0d conv=%b want epoch=1 conv=1", epoch3, conv3);
    end
  endtask

  task automatic test_nonseparable;
    write_sample(4'd0, 1, 1, 1'b1);
    write_sample(4'd1, 1, 1, 1'b0);
    w_init = 16'h0000;
    model_run(2, w_init);
    run_dut(2, 0);
    total++;
    if (epoch2 !== 4'd15 || conv2 !== 1'b0) begin
      bad++; $display("[TB] FAIL nonsep_result: got epoch=%0d conv=%b want epoch=15 conv=0", epoch2, conv2);
    end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 3; i++) write_sample(4'(i), 15, 15, 1'b0);
    w_init = {8'sd127, 8'sd127};
    model_run(3, w_init);
    run_dut(3, 0);
    total++;
    if (wout3 !== 16'hF8F8 || epoch3 !== 4'd4) begin
      bad++; $display("[TB] FAIL sat_down: got w=%h epoch=%0d want w=f8f8 epoch=4", wout3, epoch3);
    end
    write_sample(4'd0, 1, 15, 1'b0);
    write_sample(4'd1, 15, 15, 1'b1);
    write_sample(4'd2, 15, 1, 1'b1);
    w_init = 16'h7F80;
    model_run(3, w_init);
    run_dut(3, 0);
  endtask

  task automatic test_reset_mid;
    bit saw_done;
    w_init = 16'h7F80;
    @(negedge clk);
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (busy3 !== 1'b0) begin bad++; $display("[TB] FAIL midreset_busy: got %b want 0", busy3); end
    total++;
    if (wout3 !== 16'h0000) begin bad++; $display("[TB] FAIL midreset_w: got %h want 0000", wout3); end
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done3 === 1'b1 || busy3 === 1'b1) saw_done = 1'b1;
    end
    total++;
    if (saw_done) begin bad++; $display("[TB] FAIL midreset_activity: got 1 want 0"); end
    for (int i = 0; i < 16; i++) mdl_samp[i] = 9'h000;
    w_init = {8'sd1, 8'sd1};
    model_run(3, w_init);
    run_dut(3, 0);
    write_known();
    w_init = {8'sd9, 8'sd4};
    model_run(3, w_init);
    run_dut(3, 0);
  endtask

  task automatic test_busy_ignore;
    write_known();
    w_init = {8'sd9, 8'sd4};
    model_run(3, w_init);
    run_dut(3, 1);
    model_run(3, w_init);
    run_dut(3, 0);
  endtask

  task automatic test_back_to_back;
    write_sample(4'd0, 1, 2, 1'b1);
    write_sample(4'd1, 3, 4, 1'b1);
    write_sample(4'd2, 5, 6, 1'b1);
    w_init = {8'sd1, 8'sd1};
    model_run(3, w_init);
    run_dut(3, 2);
    @(negedge clk);
    total++;
    if (busy3 !== 1'b0) begin bad++; $display("[TB] FAIL done_start_ignored: got %b want 0", busy3); end
    w_init = {8'sd9, 8'sd4};
    write_known();
    model_run(3, w_init);
    run_dut(3, 0);
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    w_init  = '0;
    start3  = 1'b0;
    start2  = 1'b0;
    for (int i = 0; i < 16; i++) mdl_samp[i] = 9'h000;
    test_reset();
    test_known();
    test_all_positive();
    test_nonseparable();
    test_saturation();
    test_reset_mid();
    test_busy_ignore();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
